// File: rtl/char_power.sv
// Character power-state controller: tracks small/big/grow/shrink/invulnerable/dead
// and decodes hitbox height, flashing, physics freeze and score/bounce pulses.
module char_power #(
  parameter int unsigned GROW_FRAMES   = 24,
  parameter int unsigned INVULN_FRAMES = 120
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       frame_tick,
  input  logic       touch_g_ms,
  input  logic       touch_enemy,
  input  logic       stomp,
  output logic       char_big,
  output logic [9:0] char_h,
  output logic       grow_anim,
  output logic       flash,
  output logic       freeze,
  output logic       dead,
  output logic       bounce,
  output logic       score_add
);

  localparam logic [2:0] SMALL  = 3'd0;
  localparam logic [2:0] GROW   = 3'd1;
  localparam logic [2:0] BIG    = 3'd2;
  localparam logic [2:0] SHRINK = 3'd3;
  localparam logic [2:0] INVULN = 3'd4;
  localparam logic [2:0] DEAD   = 3'd5;

  localparam logic [7:0] GROW_CNT   = 8'(GROW_FRAMES);
  localparam logic [7:0] INVULN_CNT = 8'(INVULN_FRAMES);
  localparam logic [9:0] H_SMALL    = 10'd12;
  localparam logic [9:0] H_BIG      = 10'd24;

  logic [2:0] state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       bounce_nx, score_nx;
  logic       hit, tick_end;

  // stomp masks side contact in the same cycle
  assign hit      = touch_enemy && !stomp;
  assign tick_end = frame_tick && (cnt == 8'd1);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bounce_nx = 1'b0;
    score_nx  = 1'b0;
    case (state)
      SMALL: begin
        if (hit) begin
          state_nx = DEAD;
        end else if (touch_g_ms) begin
          state_nx = GROW;
          cnt_nx   = GROW_CNT;
          score_nx = 1'b1;
        end else if (stomp) begin
          bounce_nx = 1'b1;
        end
      end
      GROW, SHRINK: begin
        if (tick_end) begin
          if (state == GROW) begin
            state_nx = BIG;
          end else begin
            state_nx = INVULN;
            cnt_nx   = INVULN_CNT;
          end
        end else if (frame_tick) begin
          cnt_nx = cnt - 8'd1;
        end
      end
      BIG: begin
        bounce_nx = stomp;
        if (hit) begin
          state_nx = SHRINK;
          cnt_nx   = GROW_CNT;
        end else if (touch_g_ms) begin
          score_nx = 1'b1;
        end
      end
      INVULN: begin
        bounce_nx = stomp;
        if (touch_g_ms) begin
          state_nx = GROW;
          cnt_nx   = GROW_CNT;
          score_nx = 1'b1;
        end else if (tick_end) begin
          state_nx = SMALL;
        end else if (frame_tick) begin
          cnt_nx = cnt - 8'd1;
        end
      end
      DEAD: begin
        state_nx = DEAD;
      end
      default: begin
        state_nx = SMALL;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      state     <= SMALL;
      cnt       <= '0;
      bounce    <= 1'b0;
      score_add <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bounce    <= bounce_nx;
      score_add <= score_nx;
    end
  end

  always_comb begin
    char_big  = 1'b0;
    char_h    = H_SMALL;
    grow_anim = 1'b0;
    flash     = 1'b1;
    freeze    = 1'b0;
    dead      = 1'b0;
    case (state)
      GROW: begin
        char_big  = 1'b1;
        char_h    = cnt[2] ? H_BIG : H_SMALL;
        grow_anim = 1'b1;
        freeze    = 1'b1;
      end
      BIG: begin
        char_big = 1'b1;
        char_h   = H_BIG;
      end
      SHRINK: begin
        char_h    = cnt[2] ? H_BIG : H_SMALL;
        grow_anim = 1'b1;
        freeze    = 1'b1;
      end
      INVULN: begin
        flash = cnt[1];
      end
      DEAD: begin
        freeze = 1'b1;
        dead   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/char_power.md
# char_power

Character power-state controller: the consumer of the per-object touch pulses that the item and enemy blocks emit. It tracks whether the character is small, big, growing, shrinking, temporarily invulnerable or dead. It drives hitbox height, sprite flashing, physics freeze, stomp bounce and score pulses to the character-physics and render stages. All animation timing is counted in frames via `frame_tick`.

## Interface
- `GROW_FRAMES`, default 24: frames spent in GROW and in SHRINK; legal range 1–255.
- `INVULN_FRAMES`, default 120: frames of post-hit invulnerability; legal range 1–255.
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `touch_g_ms`  in  1  one-cycle pulse: a mushroom item was collected this cycle.
- `touch_enemy`  in  1  level: the character overlaps an enemy hitbox (side contact).
- `stomp`  in  1  one-cycle pulse: the character landed on an enemy from above.
- `char_big`  out  1  1 in GROW and BIG.
- `char_h`  out  10  hitbox height in pixels: 12 small, 24 big.
- `grow_anim`  out  1  1 in GROW and SHRINK.
- `flash`  out  1  sprite-visible enable.
- `freeze`  out  1  stalls character physics; 1 in GROW, SHRINK and DEAD.
- `dead`  out  1  sticky death flag.
- `bounce`  out  1  one-cycle pulse after an accepted stomp.
- `score_add`  out  1  one-cycle pulse after an accepted mushroom.

## Operation
- Six states: SMALL, GROW, BIG, SHRINK, INVULN, DEAD. Frame counter `cnt` is 8 bits.
- **Hit:** `touch_enemy` high while `stomp` is low. `stomp` masks `touch_enemy` in the same cycle.
- **SMALL**
  - hit → DEAD.
  - Else `touch_g_ms` → GROW, with `cnt` = GROW_FRAMES and `score_add` pulse.
  - Else `stomp` → `bounce` pulse.
- **GROW**
  - All touch inputs and `stomp` are ignored.
  - On `frame_tick`, `cnt` decrements. A `frame_tick` arriving when `cnt` == 1 moves to BIG.
- **BIG**
  - hit → SHRINK, with `cnt` = GROW_FRAMES. A mushroom in the same cycle is dropped (no `score_add`).
  - Else `touch_g_ms` → stay in BIG, with `score_add` pulse.
  - `stomp` → `bounce` pulse.
- **SHRINK**
  - Inputs are ignored, as in GROW.
  - On terminal `frame_tick` → INVULN, with `cnt` = INVULN_FRAMES.
- **INVULN**
  - `touch_enemy` is ignored.
  - `touch_g_ms` → GROW, with `score_add`; this takes priority over expiry in the same cycle.
  - Terminal `frame_tick` → SMALL.
  - `stomp` → `bounce` pulse.
- **DEAD**
  - Absorbing until `RST`. All inputs are ignored.
- Output decode, from the registered state:
  - `char_h`: 24 in BIG; 12 in SMALL, INVULN and DEAD.
  - In GROW and SHRINK, `char_h` = `cnt[2]` ? 24 : 12, which alternates every 4 frames.
  - `flash` = 1 in every state except INVULN, where `flash` = `cnt[1]`.
  - `dead` = 1 only in DEAD.
- Arithmetic:
  - `cnt` never decrements below 1 in a timed state.
  - `cnt` is irrelevant (held) in untimed states.
  - The `char_h` upper bits are always 0.

## Timing
- Reset values:
  - state SMALL, `cnt` = 0.
  - `char_big` = 0, `char_h` = 12, `grow_anim` = 0, `flash` = 1, `freeze` = 0, `dead` = 0, `bounce` = 0, `score_add` = 0.
- Input sampled at edge N → state and state-decoded outputs change after edge N (latency 1).
- `bounce` and `score_add` are registered pulses, high exactly one cycle, in cycle N+1.
- A timed state lasts exactly its parameter count of `frame_tick` pulses counted after entry.
  - A `frame_tick` coincident with the entering event does not count.
- A held `touch_enemy` level causes one transition only:
  - BIG → SHRINK, after which the input is ignored until INVULN expires.
  - If `touch_enemy` is still high when SMALL is re-entered, it causes DEAD on the next cycle.
- `RST` has priority over everything, in any state, mid-count included. The outputs take their reset values one cycle after `RST` is sampled.

## Test plan
- Reset, then pulse `touch_g_ms` → `score_add` high for 1 cycle, state GROW, `freeze` = 1, `char_big` = 1. After 24 `frame_tick` pulses: BIG, `char_h` = 24, `freeze` = 0.
- In BIG, raise `touch_enemy` and `touch_g_ms` together → SHRINK, no `score_add`. After 24 ticks: INVULN. `flash` toggles every 2 ticks, and `touch_enemy` held high causes nothing. After 120 ticks: SMALL, then DEAD one cycle later.
- In SMALL, `stomp` and `touch_enemy` in the same cycle → `bounce` for 1 cycle, state stays SMALL, `dead` = 0.
- In INVULN at `cnt` = 1, `frame_tick` and `touch_g_ms` in the same cycle → GROW with `score_add`; `cnt` reloads to 24.
- Assert `RST` mid-GROW at `cnt` = 10 → next cycle all outputs at reset values. After that, `frame_tick` pulses alone cause no state change.
- In DEAD, pulse `touch_g_ms`, `stomp` and 300 ticks → `dead` stays 1, `bounce` and `score_add` stay 0.
